// File: rtl/pipe_hold_ctrl_pkg.sv
// pipe_hold_ctrl_pkg: shared hold levels, bus FSM encoding and stall counter width
package pipe_hold_ctrl_pkg;
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;
  localparam int STALL_W = 32;
  typedef enum logic [1:0] {B_IDLE, B_DRAIN, B_GRANT} bus_state_t;
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating enable counter with synchronous reset
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  // count enabled cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_en && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline hold/flush merging, post-jump flush window and bus drain/grant handshake
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_hold_i,
  input  logic        clint_hold_i,
  input  logic        bus_req_i,
  output logic        bus_gnt_o,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] stall_cnt_o
);
  bus_state_t r_state, w_next;
  logic [3:0] r_flush_cnt, w_flush_nxt;
  logic [3:0] r_drain_cnt, w_drain_nxt;
  logic       r_gnt;
  logic       w_hard_hold;
  assign w_hard_hold = jump_req_i | ex_hold_i | clint_hold_i;
  assign jump_flag_o = jump_req_i;
  assign jump_addr_o = jump_req_i ? jump_addr_i : 32'h0;
  assign bus_gnt_o   = r_gnt;
  // state register; grant is registered from the next state so it rises/falls on the FSM edge
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= B_IDLE;
      r_flush_cnt <= '0;
      r_drain_cnt <= '0;
      r_gnt       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= w_flush_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_gnt       <= (w_next == B_GRANT);
    end
  // next state; a jump keeps the bus idle until the flush window closes and restarts any drain
  always_comb begin
    w_flush_nxt = jump_req_i ? 4'(FLUSH_CYCLES - 1) : r_flush_cnt - 4'(r_flush_cnt != 0);
    w_drain_nxt = (r_state != B_DRAIN || jump_req_i) ? 4'(DRAIN_CYCLES - 1)
                                                     : r_drain_cnt - 4'(r_drain_cnt != 0);
    unique case (r_state)
      B_IDLE:  w_next = (bus_req_i && !jump_req_i && r_flush_cnt == 0) ? B_DRAIN : B_IDLE;
      B_DRAIN: w_next = !bus_req_i ? B_IDLE :
                        (!jump_req_i && r_drain_cnt == 0 && !ex_hold_i && !clint_hold_i) ? B_GRANT : B_DRAIN;
      B_GRANT: w_next = bus_req_i ? B_GRANT : B_IDLE;
      default: w_next = B_IDLE;
    endcase
  end
  // hold level is the strongest active request
  always_comb
    hold_flag_o = w_hard_hold          ? HOLD_ID :
                  (r_flush_cnt != 0)   ? HOLD_IF :
                  (r_state != B_IDLE)  ? HOLD_PC : HOLD_NONE;
  pipe_sat_cnt #(.W(STALL_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .i_en  (hold_flag_o != HOLD_NONE),
    .o_cnt (stall_cnt_o)
  );
endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Pipeline hold/flush controller for the core; produces the 3-bit hold_flag consumed by the pc, if_id and id_ex pipeline registers, and forwards the jump request to the pc register.
- Merges hold requests from ex (multi-cycle op), clint (interrupt entry) and an external bus master.
- Sequences a post-jump flush window and a drain/grant handshake that hands the bus to the external master.
- Keeps a saturating stall-cycle counter.

Parameters:
- FLUSH_CYCLES, 2: total cycles of pipeline flush per jump, including the jump cycle; legal range 1..15.
- DRAIN_CYCLES, 3: cycles the PC is frozen before bus_gnt_o asserts; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- jump_req_i  in  1  ex resolves taken branch/jump this cycle
- jump_addr_i  in  32  jump target
- ex_hold_i  in  1  ex multi-cycle op busy
- clint_hold_i  in  1  clint interrupt entry in progress
- bus_req_i  in  1  external master requests the bus (level)
- bus_gnt_o  out  1  bus granted (registered)
- hold_flag_o  out  3  0=none, 1=hold pc, 2=hold pc+if_id, 3=hold pc+if_id+id_ex (bubble)
- jump_flag_o  out  1  jump to pc register
- jump_addr_o  out  32  jump target to pc register
- stall_cnt_o  out  32  cycles with hold_flag_o!=0

Behaviour:
- Reset: one clk edge with rst=1 clears all state. During and after reset, until inputs change: bus_gnt_o=0, stall_cnt_o=0, flush_cnt=0, bus FSM=B_IDLE. hold_flag_o=0, jump_flag_o=0 and jump_addr_o=0 whenever the inputs are 0. Reset mid-operation aborts flush and grant immediately.
- jump_flag_o = jump_req_i and jump_addr_o = jump_addr_i, both combinational. jump_addr_o is forced to 0 when jump_req_i=0.
- Flush counter (4 bit):
  - On jump_req_i, load FLUSH_CYCLES-1.
  - Otherwise, if nonzero, decrement.
  - A new jump while counting reloads the counter.
- hold_flag_o is combinational and equals the maximum of:
  - 3 if jump_req_i, clint_hold_i or ex_hold_i;
  - 2 if flush_cnt!=0;
  - 1 if bus FSM is not B_IDLE;
  - else 0.
- Bus FSM, states B_IDLE, B_DRAIN, B_GRANT:
  - B_IDLE: bus_req_i & !jump_req_i & flush_cnt==0 -> B_DRAIN, drain_cnt=DRAIN_CYCLES-1.
  - B_DRAIN: !bus_req_i -> B_IDLE.
  - B_DRAIN, jump_req_i -> stay in B_DRAIN, reload drain_cnt=DRAIN_CYCLES-1.
  - B_DRAIN, drain_cnt==0 & !ex_hold_i & !clint_hold_i -> B_GRANT, bus_gnt_o<=1.
  - B_DRAIN otherwise: drain_cnt decrements while nonzero.
  - B_GRANT: bus_gnt_o stays 1 while bus_req_i=1.
  - B_GRANT, !bus_req_i -> B_IDLE, bus_gnt_o<=0 on the same edge.
  - Jump/ex/clint events in B_GRANT do not revoke the grant; they only raise hold_flag_o.
- Grant latency: bus_req_i rising in B_IDLE with no other holds gives bus_gnt_o high DRAIN_CYCLES+1 cycles later.
- stall_cnt_o increments by 1 on every clk edge where hold_flag_o!=0, saturates at 32'hFFFFFFFF, and never wraps.
- Simultaneous events:
  - jump_req_i with a bus_req_i rise: the jump wins; the FSM stays in B_IDLE until flush_cnt==0.
  - clint_hold_i and ex_hold_i together: level 3, no additional ordering.

Decomposition:
- Shared package / defines: HOLD_NONE=3'd0, HOLD_PC=3'd1, HOLD_IF=3'd2, HOLD_ID=3'd3; bus FSM state encodings; stall counter width.
- One natural sub-module, pipe_sat_cnt: a 32-bit saturating enable counter with sync reset, used for stall_cnt_o.

Test Plan:
- Reset with all inputs 0 -> hold_flag_o=0, bus_gnt_o=0, stall_cnt_o=0. Hold rst=1 for 3 cycles with bus_req_i=1 -> bus_gnt_o stays 0.
- Single-cycle jump_req_i=1, jump_addr_i=32'h100, FLUSH_CYCLES=2:
  - jump cycle: jump_flag_o=1, addr 32'h100, hold_flag_o=3;
  - next cycle: hold_flag_o=2;
  - then 0;
  - stall_cnt_o=2.
- bus_req_i held high, DRAIN_CYCLES=3 -> hold_flag_o=1 from the next cycle. bus_gnt_o rises exactly 4 cycles after the request. Drop bus_req_i -> bus_gnt_o=0 and hold_flag_o=0 one cycle later.
- Jump during B_DRAIN -> drain restarts; bus_gnt_o is delayed by the number of cycles already drained. ex_hold_i=1 at drain end -> grant waits until ex_hold_i=0.
- ex_hold_i=1 for 5 cycles with clint_hold_i overlapping for 2 -> hold_flag_o=3 for all 5 cycles; stall_cnt_o=5.
- Force stall_cnt to 32'hFFFFFFFE, hold 3 cycles -> stall_cnt_o=32'hFFFFFFFF and stays there.
